// File: rtl/tx_port_scheduler_pkg.sv
// Shared types for the transmit-port scheduler: flit payload,
// port owner encoding and scheduler state.
package tx_port_scheduler_pkg;

   typedef logic [15:0] flit_t;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_ACK  = 2'd1,
      OWNER_RETX = 2'd2,
      OWNER_NEW  = 2'd3
   } owner_t;

   typedef enum logic {
      TX_IDLE   = 1'b0,
      TX_LOCKED = 1'b1
   } tx_sched_state_t;

endpackage

// File: rtl/tx_port_scheduler_picker.sv
// Combinational winner selection: ack > retx > new, with new
// forced ahead of everything once the starvation guard trips.
import tx_port_scheduler_pkg::*;

module tx_priority_picker (
   input  logic   ack_valid,
   input  logic   retx_valid,
   input  logic   new_valid,
   input  logic   starve_hit,
   output owner_t winner,
   output logic   forced
);

   always_comb begin
      winner = OWNER_NONE;
      forced = new_valid && starve_hit;
      unique case (1'b1)
         forced:
            winner = OWNER_NEW;
         ack_valid && !forced:
            winner = OWNER_ACK;
         retx_valid && !ack_valid && !forced:
            winner = OWNER_RETX;
         new_valid && !retx_valid && !ack_valid && !forced:
            winner = OWNER_NEW;
         default:
            winner = OWNER_NONE;
      endcase
   end

endmodule

// File: rtl/tx_port_scheduler.sv
// Arbitrates the single transmit port among ack, retransmit and new
// packet sources; a grant holds the port until the last flit goes out.
import tx_port_scheduler_pkg::*;

module tx_port_scheduler #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   ack_valid_i,
   input  flit_t  ack_flit_i,
   input  logic   ack_last_i,
   output logic   ack_ready_o,
   input  logic   retx_valid_i,
   input  flit_t  retx_flit_i,
   input  logic   retx_last_i,
   output logic   retx_ready_o,
   input  logic   new_valid_i,
   input  flit_t  new_flit_i,
   input  logic   new_last_i,
   output logic   new_ready_o,
   output logic   tx_valid_o,
   output flit_t  tx_flit_o,
   output logic   tx_last_o,
   input  logic   tx_ready_i,
   output owner_t owner_o,
   output logic   starve_force_o
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   tx_sched_state_t state;
   owner_t          owner;
   logic [CW-1:0]   starve_cnt;
   logic            force_q;

   owner_t winner;
   logic   forced;
   logic   any_valid;
   logic   accept;

   tx_priority_picker u_picker (
      .ack_valid  (ack_valid_i),
      .retx_valid (retx_valid_i),
      .new_valid  (new_valid_i),
      .starve_hit (starve_cnt == LIMIT),
      .winner     (winner),
      .forced     (forced)
   );

   assign any_valid = ack_valid_i | retx_valid_i | new_valid_i;
   assign accept    = tx_valid_o && tx_ready_i;

   always_comb begin
      tx_valid_o   = 1'b0;
      tx_flit_o    = '0;
      tx_last_o    = 1'b0;
      ack_ready_o  = 1'b0;
      retx_ready_o = 1'b0;
      new_ready_o  = 1'b0;
      if (state == TX_LOCKED) begin
         unique case (owner)
            OWNER_ACK: begin
               tx_valid_o  = ack_valid_i;
               tx_flit_o   = ack_flit_i;
               tx_last_o   = ack_last_i;
               ack_ready_o = tx_ready_i;
            end
            OWNER_RETX: begin
               tx_valid_o   = retx_valid_i;
               tx_flit_o    = retx_flit_i;
               tx_last_o    = retx_last_i;
               retx_ready_o = tx_ready_i;
            end
            OWNER_NEW: begin
               tx_valid_o  = new_valid_i;
               tx_flit_o   = new_flit_i;
               tx_last_o   = new_last_i;
               new_ready_o = tx_ready_i;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= TX_IDLE;
         owner      <= OWNER_NONE;
         starve_cnt <= '0;
         force_q    <= 1'b0;
      end else begin
         force_q <= 1'b0;
         unique case (state)
            TX_IDLE: begin
               if (any_valid) begin
                  state   <= TX_LOCKED;
                  owner   <= winner;
                  force_q <= forced;
                  // Only higher-priority wins over a waiting new source count.
                  if (winner == OWNER_NEW)
                     starve_cnt <= '0;
                  else if (new_valid_i && starve_cnt != LIMIT)
                     starve_cnt <= starve_cnt + 1'b1;
               end
            end
            TX_LOCKED: begin
               if (accept && tx_last_o) begin
                  state <= TX_IDLE;
                  owner <= OWNER_NONE;
               end
            end
            default: begin
               state <= TX_IDLE;
               owner <= OWNER_NONE;
            end
         endcase
      end
   end

   assign owner_o        = owner;
   assign starve_force_o = force_q;

endmodule

// File: tb/tb_tx_port_scheduler.sv
// Directed checks for tx_port_scheduler: reset, lock, backpressure,
// starvation guard, mid-packet reset and valid gaps.
import tx_port_scheduler_pkg::*;

module tb_tx_port_scheduler;

   logic   clk = 1'b0;
   logic   rst_n;
   logic   ack_valid, retx_valid, new_valid;
   flit_t  ack_flit, retx_flit, new_flit;
   logic   ack_last, retx_last, new_last;
   logic   ack_ready, retx_ready, new_ready;
   logic   tx_valid, tx_last, tx_ready;
   flit_t  tx_flit;
   owner_t owner;
   logic   starve_force;

   int checks = 0;
   int errors = 0;

   tx_port_scheduler #(.STARVE_LIMIT(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ack_valid_i    (ack_valid),
      .ack_flit_i     (ack_flit),
      .ack_last_i     (ack_last),
      .ack_ready_o    (ack_ready),
      .retx_valid_i   (retx_valid),
      .retx_flit_i    (retx_flit),
      .retx_last_i    (retx_last),
      .retx_ready_o   (retx_ready),
      .new_valid_i    (new_valid),
      .new_flit_i     (new_flit),
      .new_last_i     (new_last),
      .new_ready_o    (new_ready),
      .tx_valid_o     (tx_valid),
      .tx_flit_o      (tx_flit),
      .tx_last_o      (tx_last),
      .tx_ready_i     (tx_ready),
      .owner_o        (owner),
      .starve_force_o (starve_force)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      ack_valid  = 1'b0;
      retx_valid = 1'b0;
      new_valid  = 1'b0;
      tx_ready   = 1'b1;
      rst_n      = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_txv"}, 32'(tx_valid), 0);
      chk({tag, "_own"}, 32'(owner), 32'(OWNER_NONE));
      chk({tag, "_rdy"}, {29'd0, ack_ready, retx_ready, new_ready}, 0);
      chk({tag, "_flit"}, 32'(tx_flit), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      ack_flit = 16'h0011; ack_last = 1'b1;
      retx_flit = 16'h0022; retx_last = 1'b1;
      new_flit = 16'h0033; new_last = 1'b1;
      ack_valid = 1'b1; retx_valid = 1'b1; new_valid = 1'b1;
      tx_ready = 1'b1;

      // Reset held two cycles with every source requesting
      tick(); #1;
      idle_chk("rst1");
      chk("rst1_force", 32'(starve_force), 0);
      tick(); #1;
      idle_chk("rst2");
      rst_n = 1'b1;
      #1;
      idle_chk("rel0");
      tick(); #1;
      chk("rel_own", 32'(owner), 32'(OWNER_ACK));
      chk("rel_txv", 32'(tx_valid), 1);
      chk("rel_flit", 32'(tx_flit), 32'h0011);
      chk("rel_ackrdy", 32'(ack_ready), 1);
      chk("rel_retxrdy", 32'(retx_ready), 0);

      // Multi-flit lock on RETX; ACK arrives mid-packet
      do_reset();
      retx_valid = 1'b1; retx_flit = 16'h00A1; retx_last = 1'b0;
      #1;
      chk("lk_idle_txv", 32'(tx_valid), 0);
      tick(); #1;
      chk("lk_own", 32'(owner), 32'(OWNER_RETX));
      chk("lk_f1", 32'(tx_flit), 32'h00A1);
      chk("lk_rdy1", 32'(retx_ready), 1);
      tick();
      retx_flit = 16'h00A2;
      ack_valid = 1'b1; ack_flit = 16'h0055; ack_last = 1'b1;
      #1;
      chk("lk_f2", 32'(tx_flit), 32'h00A2);
      chk("lk_ack2", 32'(ack_ready), 0);
      tick();
      retx_flit = 16'h00A3; retx_last = 1'b1;
      #1;
      chk("lk_f3", 32'(tx_flit), 32'h00A3);
      chk("lk_last3", 32'(tx_last), 1);
      chk("lk_ack3", 32'(ack_ready), 0);
      tick();
      retx_valid = 1'b0;
      #1;
      idle_chk("lk_bubble");
      tick(); #1;
      chk("lk_ackown", 32'(owner), 32'(OWNER_ACK));
      chk("lk_ackflit", 32'(tx_flit), 32'h0055);
      chk("lk_ackrdy", 32'(ack_ready), 1);

      // Backpressure inside a NEW packet
      do_reset();
      new_valid = 1'b1; new_flit = 16'h0031; new_last = 1'b0;
      tick(); #1;
      chk("bp_own", 32'(owner), 32'(OWNER_NEW));
      chk("bp_f1", 32'(tx_flit), 32'h0031);
      tick();
      new_flit = 16'h0032; tx_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_flit", 32'(tx_flit), 32'h0032);
         chk("bp_hold_rdy", 32'(new_ready), 0);
         chk("bp_hold_txv", 32'(tx_valid), 1);
         if (i < 2) begin tick(); #1; end
      end
      tick();
      tx_ready = 1'b1;
      #1;
      chk("bp_resume_flit", 32'(tx_flit), 32'h0032);
      chk("bp_resume_rdy", 32'(new_ready), 1);
      tick();
      new_flit = 16'h0033; new_last = 1'b1;
      #1;
      chk("bp_f3", 32'(tx_flit), 32'h0033);
      chk("bp_last", 32'(tx_last), 1);
      tick();
      new_valid = 1'b0;
      #1;
      idle_chk("bp_done");

      // Starvation guard: ACK x4 then forced NEW, twice over
      do_reset();
      ack_valid = 1'b1; ack_last = 1'b1; ack_flit = 16'h0066;
      new_valid = 1'b1; new_last = 1'b1; new_flit = 16'h0077;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("sv_ack_own", 32'(owner), 32'(OWNER_ACK));
            chk("sv_ack_force", 32'(starve_force), 0);
            tick(); #1;
            chk("sv_gap_own", 32'(owner), 32'(OWNER_NONE));
         end
         tick(); #1;
         chk("sv_new_own", 32'(owner), 32'(OWNER_NEW));
         chk("sv_new_force", 32'(starve_force), 1);
         chk("sv_new_flit", 32'(tx_flit), 32'h0077);
         chk("sv_new_rdy", 32'(new_ready), 1);
         chk("sv_cnt_clr", 32'(dut.starve_cnt), 0);
         tick(); #1;
         chk("sv_force_drop", 32'(starve_force), 0);
         chk("sv_after_own", 32'(owner), 32'(OWNER_NONE));
      end
      tick(); #1;
      chk("sv_ack_again", 32'(owner), 32'(OWNER_ACK));

      // Reset during the 2nd of 4 NEW flits; pending RETX wins after
      do_reset();
      new_valid = 1'b1; new_flit = 16'h0041; new_last = 1'b0;
      tick(); #1;
      chk("mr_own", 32'(owner), 32'(OWNER_NEW));
      tick();
      new_flit = 16'h0042;
      #1;
      chk("mr_f2", 32'(tx_flit), 32'h0042);
      rst_n = 1'b0;
      retx_valid = 1'b1; retx_flit = 16'h0088; retx_last = 1'b1;
      tick(); #1;
      idle_chk("mr_rst");
      rst_n = 1'b1;
      new_flit = 16'h0041;
      tick(); #1;
      chk("mr_retx_own", 32'(owner), 32'(OWNER_RETX));
      chk("mr_retx_flit", 32'(tx_flit), 32'h0088);
      chk("mr_new_rdy", 32'(new_ready), 0);

      // Owner drops valid for two cycles mid-packet
      do_reset();
      retx_valid = 1'b1; retx_flit = 16'h00B1; retx_last = 1'b0;
      tick(); #1;
      chk("vg_own", 32'(owner), 32'(OWNER_RETX));
      tick();
      retx_valid = 1'b0;
      ack_valid = 1'b1; ack_flit = 16'h0099; ack_last = 1'b1;
      new_valid = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
         chk("vg_txv", 32'(tx_valid), 0);
         chk("vg_own_hold", 32'(owner), 32'(OWNER_RETX));
         chk("vg_ack_rdy", 32'(ack_ready), 0);
         chk("vg_new_rdy", 32'(new_ready), 0);
         tick(); #1;
      end
      retx_valid = 1'b1; retx_flit = 16'h00B2; retx_last = 1'b1;
      #1;
      chk("vg_resume_txv", 32'(tx_valid), 1);
      chk("vg_resume_flit", 32'(tx_flit), 32'h00B2);
      chk("vg_resume_own", 32'(owner), 32'(OWNER_RETX));
      tick();
      retx_valid = 1'b0;
      #1;
      idle_chk("vg_bubble");
      tick(); #1;
      chk("vg_ack_own", 32'(owner), 32'(OWNER_ACK));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_port_scheduler.md
# tx_port_scheduler

Schedules the node's single transmit port among three packet sources: the ack generator, the retransmit path fed by `waiting_ack_controller`, and the new-packet source. Fixed priority applies: ack > retransmit > new. A starvation guard ensures new traffic progresses under sustained retransmission. A grant locks the port for a whole multi-flit packet, until its last flit is accepted. The block sits between the three sources and the link transmitter.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive higher-priority packet grants tolerated while new traffic waits; must be ≥1.

Ports (`SRC` ∈ {ack, retx, new}; one group per source):
- `clk`  in  1  system clock, single clock domain
- `rst_n`  in  1  synchronous, active-low reset
- `SRC_valid_i`  in  1  source has a flit
- `SRC_flit_i`  in  flit_t  flit payload (`packet_types::flit_t`)
- `SRC_last_i`  in  1  flit is last of packet
- `SRC_ready_o`  out  1  flit accepted this cycle
- `tx_valid_o`  out  1  flit presented to transmitter
- `tx_flit_o`  out  flit_t  flit to transmitter
- `tx_last_o`  out  1  last flit of packet
- `tx_ready_i`  in  1  transmitter accepts
- `owner_o`  out  2  current owner (owner_t encoding)
- `starve_force_o`  out  1  one-cycle pulse: current grant was forced by starvation guard

## Operation
- States: IDLE, LOCKED. Registered `owner` ∈ {NONE, ACK, RETX, NEW}.
- IDLE:
  - `tx_valid_o`=0 and all `*_ready_o`=0.
  - If any `SRC_valid_i`, pick a winner, register it as `owner`, go to LOCKED.
- Winner selection:
  - If `new_valid_i` and `starve_cnt`==`STARVE_LIMIT`, pick NEW and pulse `starve_force_o` on the LOCKED entry cycle.
  - Otherwise pick the first valid source of ACK, RETX, NEW.
- Starvation counter `starve_cnt` (width $clog2(STARVE_LIMIT+1)):
  - +1 when ACK or RETX wins while `new_valid_i`=1, saturating at `STARVE_LIMIT`.
  - Cleared when NEW wins.
  - Unchanged otherwise.
- LOCKED:
  - `tx_valid_o`/`tx_flit_o`/`tx_last_o` are a combinational mux of the owner's inputs.
  - `owner_ready_o` = `tx_ready_i`; all other readies are 0.
  - Accept = `tx_valid_o` && `tx_ready_i`.
  - Accept with `tx_last_o`=1: go to IDLE, `owner`←NONE.
- Owner deasserts valid mid-packet:
  - `tx_valid_o` follows low; lock is retained.
  - Other sources are not granted until the owner's last flit is accepted.
- Sources must hold `valid`/`flit`/`last` stable until accepted; the block does not check this.
- Simultaneous requests in IDLE: only the winner advances. Losers keep `valid` high and see `ready`=0.
- A single-flit packet is just `last`=1 on its first flit.

## Timing
- Arbitration is registered:
  - request visible in IDLE at cycle N → `owner_o` and `tx_valid_o` valid from cycle N+1.
- Last-flit accept at cycle M → IDLE at M+1 (`tx_valid_o`=0) → next packet's flit at M+2 earliest.
  - Back-to-back packets therefore have a 1-cycle bubble.
- Throughput inside a packet: 1 flit/cycle while `tx_ready_i`=1.
- Reset (`rst_n`=0 at a rising edge), including mid-packet:
  - state=IDLE, `owner`=NONE, `starve_cnt`=0.
  - The in-flight packet is abandoned without draining.
- Output values during and after reset until the next grant:
  - `tx_valid_o`=0, all `*_ready_o`=0, `owner_o`=NONE, `starve_force_o`=0.
  - `tx_flit_o` and `tx_last_o` = 0 while the owner is NONE.

## Structure
- Shared package `types`:
  - `owner_t` enum {OWNER_NONE=0, OWNER_ACK=1, OWNER_RETX=2, OWNER_NEW=3}.
  - `tx_sched_state_t` enum {TX_IDLE, TX_LOCKED}.
- `flit_t` comes from `packet_types`.
- One natural sub-module: `tx_priority_picker`.
  - Combinational; inputs: three valids, starve_hit.
  - Outputs: `owner_t` winner, forced flag.
- The registered state, counter and output mux stay in `tx_port_scheduler`.

## Test plan
- **Reset:** hold `rst_n`=0 two cycles with all valids high → `tx_valid_o`=0, all readies 0, `owner_o`=NONE. After release → ACK wins one cycle later.
- **Multi-flit lock:**
  - Stimulus: RETX sends a 3-flit packet 0xA1,0xA2,0xA3 with `tx_ready_i`=1. ACK asserts valid at the 2nd flit.
  - Required: flits out on consecutive cycles; `ack_ready_o` stays 0; idle cycle; then ACK is granted.
- **Backpressure:**
  - Stimulus: `tx_ready_i`=0 for 3 cycles mid-packet.
  - Required: `tx_flit_o` holds the value, `owner_ready_o`=0; resumes on `tx_ready_i`=1.
- **Starvation guard:**
  - Stimulus: STARVE_LIMIT=4; ACK and NEW valid continuously; all packets single-flit.
  - Required: grants ACK×4, then NEW with `starve_force_o` pulsed once, then ACK again; `starve_cnt` cleared.
- **Reset mid-packet:**
  - Stimulus: `rst_n`=0 during the 2nd of 4 NEW flits.
  - Required: next cycle IDLE, `new_ready_o`=0; after release, a pending RETX beats NEW.
- **Valid gap:**
  - Stimulus: owner drops valid for 2 cycles mid-packet.
  - Required: `tx_valid_o`=0 for those cycles; `owner_o` unchanged; other sources not granted.
